// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with integrated pending-write scoreboard
//
// Architectural register store plus per-register pending-write marks.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
//
// Ports:
//   clk                    clock, all state updates on rising edge
//   rst                    asynchronous active-low reset
//   read_reg1/2            read addresses (combinational read)
//   read_data1/2           read data
//   read_busy1/2           addressed register has a pending write
//   write/write_reg/write_data   writeback port
//   issue/issue_reg        mark a destination register pending
//   flush                  clear every pending mark
//   busy_count             registered number of pending registers

module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read_reg1,
  input  logic [AW-1:0]    read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2,
  output logic             read_busy1,
  output logic             read_busy2,
  input  logic             write,
  input  logic [AW-1:0]    write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic             issue,
  input  logic [AW-1:0]    issue_reg,
  input  logic             flush,
  output logic [AW:0]      busy_count
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic [AW:0]      count_nxt;

  // Register 0 is hardwired: writes and issues to it are dropped here.
  logic wr_ok;
  logic iss_ok;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_ok  = write && (write_reg != '0);
  assign iss_ok = issue && (issue_reg != '0);

  // Count moves only when a pend bit actually flips, so busy_count tracks
  // popcount(pend) without an adder tree. An issue to the register being
  // written keeps it pending (the new producer wins), so that write does
  // not decrement.
  assign cnt_inc = iss_ok && !pend[issue_reg];
  assign cnt_dec = wr_ok && pend[write_reg] && !(iss_ok && (issue_reg == write_reg));

  always_comb begin
    pend_nxt = pend;
    if (wr_ok) begin
      pend_nxt[write_reg] = 1'b0;
    end
    if (iss_ok) begin
      pend_nxt[issue_reg] = 1'b1;
    end
    if (flush) begin
      pend_nxt = '0;
    end
  end

  always_comb begin
    count_nxt = busy_count;
    if (flush) begin
      count_nxt = '0;
    end else if (cnt_inc && !cnt_dec) begin
      count_nxt = busy_count + {{AW{1'b0}}, 1'b1};
    end else if (cnt_dec && !cnt_inc) begin
      count_nxt = busy_count - {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok) begin
        regs[write_reg] <= write_data;
      end
      pend       <= pend_nxt;
      busy_count <= count_nxt;
    end
  end

  // Read ports. Address 0 is forced to zero/not-busy independent of storage.
  always_comb begin
    read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
    read_busy1 = (read_reg1 == '0) ? 1'b0 : pend[read_reg1];
    read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
    read_busy2 = (read_reg2 == '0) ? 1'b0 : pend[read_reg2];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write. Gated by rst so the ports stay zero while
    // reset is held. The bypassed register shows busy only if it is being
    // re-issued in the same cycle and not flushed.
    if (rst && wr_ok && (read_reg1 == write_reg)) begin
      read_data1 = write_data;
      read_busy1 = iss_ok && (issue_reg == write_reg) && !flush;
    end
    if (rst && wr_ok && (read_reg2 == write_reg)) begin
      read_data2 = write_data;
      read_busy2 = iss_ok && (issue_reg == write_reg) && !flush;
    end
`endif
  end

endmodule
